// File: rtl/s247_core_dispatcher.sv
// Host-side sequencer for one s247_compute_core: queues GPS fixes, launches one
// geofence job per fix and reports each outcome; violations and timeouts lock it.
module s247_core_dispatcher #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SEQ_WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_addr,
    input  logic [DATA_WIDTH-1:0]         cfg_wdata,
    input  logic                          fix_valid,
    output logic                          fix_ready,
    input  logic [DATA_WIDTH-1:0]         fix_lat,
    input  logic [DATA_WIDTH-1:0]         fix_lon,
    output logic                          core_enable,
    output logic [DATA_WIDTH-1:0]         core_gps_lat,
    output logic [DATA_WIDTH-1:0]         core_gps_lon,
    output logic [DATA_WIDTH-1:0]         core_fence_lat,
    output logic [DATA_WIDTH-1:0]         core_fence_lon,
    output logic [DATA_WIDTH-1:0]         core_fence_rad,
    input  logic [DATA_WIDTH-1:0]         core_result,
    input  logic                          core_done,
    input  logic                          core_halt,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [DATA_WIDTH-1:0]         rpt_result,
    output logic [1:0]                    rpt_status,
    output logic [SEQ_WIDTH-1:0]          rpt_seq,
    output logic                          locked,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] STS_OK        = 2'd0;
    localparam logic [1:0] STS_VIOLATION = 2'd1;
    localparam logic [1:0] STS_TIMEOUT   = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, REPORT, LOCKED} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  stage_lat;
    logic [DATA_WIDTH-1:0]  stage_lon;
    logic [DATA_WIDTH-1:0]  stage_rad;
    logic [DATA_WIDTH-1:0]  lat_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  lon_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [TMR_W-1:0]       timer;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fix_ready = !full && !locked;
    assign push      = fix_valid && fix_ready;
    assign pop       = (state == IDLE) && (fifo_level != '0) && !core_halt;

    // Staging registers take writes at any time; the core only sees them at launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_lat <= '0;
            stage_lon <= '0;
            stage_rad <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    stage_lat <= cfg_wdata;
                2'd1:    stage_lon <= cfg_wdata;
                2'd2:    stage_rad <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lat_mem[wr_ptr] <= fix_lat;
            lon_mem[wr_ptr] <= fix_lon;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Job sequencer; a halt outranks done, which outranks the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            core_enable    <= 1'b0;
            core_gps_lat   <= '0;
            core_gps_lon   <= '0;
            core_fence_lat <= '0;
            core_fence_lon <= '0;
            core_fence_rad <= '0;
            timer          <= '0;
            rpt_valid      <= 1'b0;
            rpt_result     <= '0;
            rpt_status     <= STS_OK;
            rpt_seq        <= '0;
            locked         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_halt) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else if (fifo_level != '0) begin
                        core_gps_lat   <= lat_mem[rd_ptr];
                        core_gps_lon   <= lon_mem[rd_ptr];
                        core_fence_lat <= stage_lat;
                        core_fence_lon <= stage_lon;
                        core_fence_rad <= stage_rad;
                        core_enable    <= 1'b1;
                        timer          <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    core_enable <= 1'b0;
                    timer       <= timer + TMR_W'(1);
                    if (core_halt || core_done || timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        rpt_result <= core_result;
                        rpt_valid  <= 1'b1;
                        state      <= REPORT;
                        if (core_halt)
                            rpt_status <= STS_VIOLATION;
                        else if (core_done)
                            rpt_status <= STS_OK;
                        else
                            rpt_status <= STS_TIMEOUT;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        rpt_seq   <= rpt_seq + SEQ_WIDTH'(1);
                        if (rpt_status == STS_OK) begin
                            state <= IDLE;
                        end else begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    locked <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s247_core_dispatcher.sv
// Directed bench for s247_core_dispatcher with a small behavioural core stand-in.
module tb_s247_core_dispatcher;

    localparam int DW  = 32;
    localparam int SW  = 8;
    localparam int TOC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          fix_valid;
    logic          fix_ready;
    logic [DW-1:0] fix_lat;
    logic [DW-1:0] fix_lon;
    logic          core_enable;
    logic [DW-1:0] core_gps_lat;
    logic [DW-1:0] core_gps_lon;
    logic [DW-1:0] core_fence_lat;
    logic [DW-1:0] core_fence_lon;
    logic [DW-1:0] core_fence_rad;
    logic [DW-1:0] core_result;
    logic          core_done;
    logic          core_halt;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [DW-1:0] rpt_result;
    logic [1:0]    rpt_status;
    logic [SW-1:0] rpt_seq;
    logic          locked;
    logic [2:0]    fifo_level;

    logic [1:0]    core_mode;
    logic          stray_done;
    logic [1:0]    core_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    s247_core_dispatcher #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TOC), .SEQ_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .fix_valid(fix_valid), .fix_ready(fix_ready), .fix_lat(fix_lat), .fix_lon(fix_lon),
        .core_enable(core_enable), .core_gps_lat(core_gps_lat), .core_gps_lon(core_gps_lon),
        .core_fence_lat(core_fence_lat), .core_fence_lon(core_fence_lon),
        .core_fence_rad(core_fence_rad), .core_result(core_result),
        .core_done(core_done), .core_halt(core_halt),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_result(rpt_result),
        .rpt_status(rpt_status), .rpt_seq(rpt_seq), .locked(locked), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Core stand-in: mode 0 answers done, mode 1 halts, mode 2 stays silent.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt  <= 2'd0;
            core_done <= 1'b0;
            core_halt <= 1'b0;
        end else begin
            core_done <= stray_done;
            if (core_enable && core_mode != 2'd2) begin
                core_cnt <= 2'd3;
            end else if (core_cnt != 2'd0) begin
                core_cnt <= core_cnt - 2'd1;
                if (core_cnt == 2'd1) begin
                    if (core_mode == 2'd0) core_done <= 1'b1;
                    else                   core_halt <= 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0; fix_valid = 1'b0; rpt_ready = 1'b0;
        stray_done = 1'b0; core_mode = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [DW-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_fix(input logic [DW-1:0] lat, input logic [DW-1:0] lon);
        fix_valid = 1'b1; fix_lat = lat; fix_lon = lon;
        @(negedge clk);
        fix_valid = 1'b0;
    endtask

    task automatic wait_rpt(output int cyc, output int enables);
        cyc = 0; enables = 0;
        while (cyc < 40 && !rpt_valid) begin
            @(negedge clk);
            cyc++;
            if (core_enable) enables++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (fix_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_fix_ready: got %b expected 1", fix_ready); end
        n_checks++; if ({core_enable, locked, rpt_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {core_enable, locked, rpt_valid}); end
        n_checks++; if ({core_gps_lat, core_gps_lon, core_fence_lat, core_fence_lon, core_fence_rad} !== '0) begin n_fail++; $display("[TB] FAIL reset_operands: got nonzero expected 0"); end
        n_checks++; if ({rpt_result, rpt_status, rpt_seq} !== '0) begin n_fail++; $display("[TB] FAIL reset_report: got %h/%0d/%0d expected 0/0/0", rpt_result, rpt_status, rpt_seq); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_nominal();
        int cyc, en;
        do_reset();
        core_result = 32'h0000_4000;
        cfg_write(2'd0, 32'h0001_0000);
        cfg_write(2'd1, 32'h0001_0000);
        cfg_write(2'd2, 32'h0002_0000);
        cfg_write(2'd3, 32'hFFFF_FFFF);
        push_fix(32'h0001_8000, 32'h0001_0000);
        n_checks++; if ({fifo_level, core_enable} !== {3'd1, 1'b0}) begin n_fail++; $display("[TB] FAIL nom_queued: got level %0d en %b expected 1 0", fifo_level, core_enable); end
        @(negedge clk);
        n_checks++; if ({core_enable, fifo_level} !== {1'b1, 3'd0}) begin n_fail++; $display("[TB] FAIL nom_launch: got en %b level %0d expected 1 0", core_enable, fifo_level); end
        n_checks++; if ({core_gps_lat, core_gps_lon, core_fence_lat, core_fence_lon, core_fence_rad} !==
                        {32'h0001_8000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000}) begin
            n_fail++; $display("[TB] FAIL nom_operands: got %h %h %h %h %h", core_gps_lat, core_gps_lon, core_fence_lat, core_fence_lon, core_fence_rad);
        end
        wait_rpt(cyc, en);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("[TB] FAIL nom_latency: got %0d expected 5", cyc); end
        n_checks++; if ({rpt_valid, rpt_status, rpt_seq, rpt_result} !== {1'b1, 2'd0, 8'd0, 32'h0000_4000}) begin
            n_fail++; $display("[TB] FAIL nom_report: got v%b st%0d seq%0d res %h expected v1 st0 seq0 res 00004000", rpt_valid, rpt_status, rpt_seq, rpt_result);
        end
        n_checks++; if (en !== 0) begin n_fail++; $display("[TB] FAIL nom_enable_once: got %0d extra pulses expected 0", en); end
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        n_checks++; if ({rpt_valid, rpt_seq, locked, fix_ready} !== {1'b0, 8'd1, 1'b0, 1'b1}) begin
            n_fail++; $display("[TB] FAIL nom_handshake: got v%b seq%0d lk%b rdy%b expected v0 seq1 lk0 rdy1", rpt_valid, rpt_seq, locked, fix_ready);
        end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({rpt_valid, core_enable, rpt_seq} !== {1'b0, 1'b0, 8'd1}) begin
            n_fail++; $display("[TB] FAIL idle_stray_done: got v%b en%b seq%0d expected v0 en0 seq1", rpt_valid, core_enable, rpt_seq);
        end
    endtask

    task automatic test_back_pressure();
        int accepted, launched, got;
        logic seen, unstable;
        logic [42:0] snap;
        do_reset();
        core_result = 32'h0000_4000;
        accepted = 0; seen = 1'b0; unstable = 1'b0; snap = '0;
        for (int c = 0; c < 30; c++) begin
            fix_valid = (accepted < 8);
            fix_lat = 32'(32'h100 + accepted); fix_lon = 32'h0;
            if (fix_valid && fix_ready) accepted++;
            if (seen && {rpt_valid, rpt_status, rpt_seq, rpt_result} !== snap) unstable = 1'b1;
            if (rpt_valid && !seen) begin seen = 1'b1; snap = {rpt_valid, rpt_status, rpt_seq, rpt_result}; end
            @(negedge clk);
        end
        fix_valid = 1'b0;
        n_checks++; if (accepted !== 5) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d expected 5", accepted); end
        n_checks++; if ({fifo_level, fix_ready} !== {3'd4, 1'b0}) begin n_fail++; $display("[TB] FAIL bp_full: got level %0d rdy %b expected 4 0", fifo_level, fix_ready); end
        n_checks++; if ({seen, unstable, rpt_valid, rpt_seq, rpt_result} !== {1'b1, 1'b0, 1'b1, 8'd0, 32'h0000_4000}) begin
            n_fail++; $display("[TB] FAIL bp_held: got seen%b unstable%b v%b seq%0d res %h", seen, unstable, rpt_valid, rpt_seq, rpt_result);
        end
        rpt_ready = 1'b1;
        launched = 1; got = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            if (core_enable) begin
                n_checks++; if (core_gps_lat !== 32'(32'h100 + launched)) begin n_fail++; $display("[TB] FAIL bp_order: got %h expected %h", core_gps_lat, 32'h100 + launched); end
                launched++;
            end
            if (rpt_valid) begin
                n_checks++; if ({rpt_status, rpt_seq} !== {2'd0, 8'(got)}) begin n_fail++; $display("[TB] FAIL bp_report: got st%0d seq%0d expected st0 seq%0d", rpt_status, rpt_seq, got); end
                got++;
            end
            @(negedge clk);
        end
        rpt_ready = 1'b0;
        n_checks++; if ({got, launched} !== {32'd5, 32'd5}) begin n_fail++; $display("[TB] FAIL bp_count: got %0d reports %0d launches expected 5 5", got, launched); end
    endtask

    task automatic test_config_isolation();
        int cyc, en;
        do_reset();
        rpt_ready = 1'b1;
        core_result = 32'h0000_0100;
        cfg_write(2'd2, 32'h0002_0000);
        push_fix(32'h0000_1000, 32'h0000_2000);
        for (int c = 0; c < 10 && !core_enable; c++) @(negedge clk);
        cfg_write(2'd2, 32'h0005_0000);
        n_checks++; if (core_fence_rad !== 32'h0002_0000) begin n_fail++; $display("[TB] FAIL cfg_stable: got %h expected 00020000", core_fence_rad); end
        wait_rpt(cyc, en);
        @(negedge clk);
        push_fix(32'h0000_3000, 32'h0000_4000);
        @(negedge clk);
        n_checks++; if ({core_enable, core_fence_rad} !== {1'b1, 32'h0005_0000}) begin
            n_fail++; $display("[TB] FAIL cfg_next_launch: got en%b rad %h expected en1 rad 00050000", core_enable, core_fence_rad);
        end
    endtask

    task automatic test_violation();
        int cyc, en;
        do_reset();
        core_mode = 2'd1;
        core_result = 32'h0001_0000;
        cfg_write(2'd0, 32'h0001_0000);
        cfg_write(2'd1, 32'h0001_0000);
        cfg_write(2'd2, 32'h0000_1000);
        push_fix(32'h0002_0000, 32'h0001_0000);
        push_fix(32'h0002_0000, 32'h0001_0000);
        push_fix(32'h0002_0000, 32'h0001_0000);
        wait_rpt(cyc, en);
        n_checks++; if ({rpt_valid, rpt_status, rpt_result} !== {1'b1, 2'd1, 32'h0001_0000}) begin
            n_fail++; $display("[TB] FAIL viol_report: got v%b st%0d res %h expected v1 st1 res 00010000", rpt_valid, rpt_status, rpt_result);
        end
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        n_checks++; if ({locked, fix_ready, rpt_valid} !== 3'b100) begin n_fail++; $display("[TB] FAIL viol_locked: got lk%b rdy%b v%b expected 1 0 0", locked, fix_ready, rpt_valid); end
        en = 0;
        fix_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_enable) en++;
        end
        fix_valid = 1'b0;
        n_checks++; if ({en, 29'd0, fifo_level} !== {32'd0, 29'd0, 3'd2}) begin n_fail++; $display("[TB] FAIL viol_inert: got %0d launches level %0d expected 0 2", en, fifo_level); end
    endtask

    task automatic test_timeout();
        int cyc, en;
        do_reset();
        core_mode = 2'd2;
        core_result = 32'hDEAD_BEEF;
        push_fix(32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        n_checks++; if (core_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL to_launch: got %b expected 1", core_enable); end
        wait_rpt(cyc, en);
        n_checks++; if (cyc !== TOC) begin n_fail++; $display("[TB] FAIL to_latency: got %0d expected %0d", cyc, TOC); end
        n_checks++; if ({rpt_status, rpt_result} !== {2'd2, 32'hDEAD_BEEF}) begin n_fail++; $display("[TB] FAIL to_report: got st%0d res %h expected st2 res deadbeef", rpt_status, rpt_result); end
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        n_checks++; if ({locked, fix_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL to_locked: got lk%b rdy%b expected 1 0", locked, fix_ready); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc, en;
        do_reset();
        rpt_ready = 1'b1;
        core_result = 32'h0000_0042;
        cfg_write(2'd2, 32'h0000_7000);
        push_fix(32'h0000_0011, 32'h0000_0022);
        wait_rpt(cyc, en);
        @(negedge clk);
        n_checks++; if (rpt_seq !== 8'd1) begin n_fail++; $display("[TB] FAIL mid_pre_seq: got %0d expected 1", rpt_seq); end
        core_mode = 2'd2;
        for (int i = 0; i < 4; i++) push_fix(32'(32'h200 + i), 32'h0);
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("[TB] FAIL mid_queued: got %0d expected 3", fifo_level); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({fix_ready, core_enable, locked, rpt_valid, fifo_level} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("[TB] FAIL mid_reset_flags: got rdy%b en%b lk%b v%b lvl%0d expected 1 0 0 0 0", fix_ready, core_enable, locked, rpt_valid, fifo_level);
        end
        n_checks++; if ({core_gps_lat, core_fence_rad, rpt_result, rpt_status, rpt_seq} !== '0) begin
            n_fail++; $display("[TB] FAIL mid_reset_regs: got gps %h rad %h res %h st%0d seq%0d expected all 0", core_gps_lat, core_fence_rad, rpt_result, rpt_status, rpt_seq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        core_mode = 2'd0;
        @(negedge clk);
        push_fix(32'h0000_0033, 32'h0000_0044);
        wait_rpt(cyc, en);
        n_checks++; if ({rpt_valid, rpt_status, rpt_seq} !== {1'b1, 2'd0, 8'd0}) begin
            n_fail++; $display("[TB] FAIL mid_post_seq: got v%b st%0d seq%0d expected v1 st0 seq0", rpt_valid, rpt_status, rpt_seq);
        end
    endtask

    initial begin
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        fix_valid = 1'b0; fix_lat = '0; fix_lon = '0;
        rpt_ready = 1'b0; core_result = '0;
        core_mode = 2'd0; stray_done = 1'b0;
        test_reset();
        test_nominal();
        test_back_pressure();
        test_config_isolation();
        test_violation();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
